// File: rtl/tnoc_flit_arbiter_pkg.sv
// tnoc_flit_arbiter_pkg: flit control-bit helpers and arbiter state encoding
package tnoc_flit_arbiter_pkg;
  localparam int HEAD_BIT = 0;
  localparam int TAIL_BIT = 1;
  typedef enum logic {IDLE, LOCKED} state_e;
  function automatic logic is_head(input logic [1:0] ctrl);
    return ctrl[HEAD_BIT];
  endfunction
  function automatic logic is_tail(input logic [1:0] ctrl);
    return ctrl[TAIL_BIT];
  endfunction
endpackage

// File: rtl/tnoc_round_robin_arbiter.sv
// tnoc_round_robin_arbiter: combinational one-hot pick of the first request at or after ptr
module tnoc_round_robin_arbiter #(
  parameter int REQUESTERS = 4,
  localparam int PW = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] request,
  input  logic [PW-1:0]         ptr,
  input  logic                  enable,
  output logic [REQUESTERS-1:0] grant
);
  logic [REQUESTERS-1:0] hi, pick;
  // Requests at or above the pointer take priority; otherwise wrap to the lowest index
  assign hi    = request & ~((REQUESTERS'(1) << ptr) - REQUESTERS'(1));
  assign pick  = |hi ? hi : request;
  assign grant = enable ? pick & (~pick + REQUESTERS'(1)) : '0;
endmodule

// File: rtl/tnoc_flit_vc_arbiter.sv
// tnoc_flit_vc_arbiter: packet-granular round-robin sharing of one downstream flit channel
module tnoc_flit_vc_arbiter
  import tnoc_flit_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int FLIT_WIDTH = 64,
  localparam int PW = $clog2(REQUESTERS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [REQUESTERS-1:0]            i_valid,
  output logic [REQUESTERS-1:0]            o_ready,
  input  logic [REQUESTERS*FLIT_WIDTH-1:0] i_flit,
  output logic [REQUESTERS-1:0]            o_vc_available,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [FLIT_WIDTH-1:0]            o_flit,
  input  logic                             i_vc_available,
  output logic [REQUESTERS-1:0]            o_grant,
  output logic                             o_busy
);
  state_e                state;
  logic [REQUESTERS-1:0] owner, head_req, rr_grant, grant_eff;
  logic [PW-1:0]         ptr, win_idx, ptr_nxt;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic                  stage_free, xfer;
  for (genvar k = 0; k < REQUESTERS; k++) begin : g_req
    assign head_req[k] = i_valid[k] && is_head(i_flit[k*FLIT_WIDTH +: 2]);
  end
  assign stage_free = !o_valid || i_ready;
  // rst_n gates the combinational grant so nothing is offered while reset is held
  tnoc_round_robin_arbiter #(.REQUESTERS(REQUESTERS)) u_rr (
    .request (head_req),
    .ptr     (ptr),
    .enable  (rst_n && state == IDLE && i_vc_available && stage_free),
    .grant   (rr_grant)
  );
  assign grant_eff      = state == LOCKED ? owner : rr_grant;
  assign o_grant        = grant_eff;
  assign o_ready        = grant_eff & i_valid & {REQUESTERS{stage_free}};
  assign xfer           = |o_ready;
  assign o_busy         = state == LOCKED;
  assign o_vc_available = {REQUESTERS{i_vc_available}};
  always_comb begin
    sel_flit = '0;
    win_idx  = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      sel_flit = sel_flit | (i_flit[k*FLIT_WIDTH +: FLIT_WIDTH] & {FLIT_WIDTH{grant_eff[k]}});
      win_idx  = grant_eff[k] ? PW'(k) : win_idx;
    end
  end
  assign ptr_nxt = win_idx == PW'(REQUESTERS-1) ? '0 : win_idx + PW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      o_valid <= 1'b0;
      o_flit  <= '0;
    end else begin
      if (xfer) begin
        o_flit  <= sel_flit;
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      if (xfer && is_tail(sel_flit[1:0])) begin
        state <= IDLE;
        ptr   <= ptr_nxt;
      end else if (xfer && state == IDLE) begin
        state <= LOCKED;
        owner <= grant_eff;
      end
    end
  end
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(o_grant));
  a_ready_subset: assert property (@(posedge clk) disable iff (!rst_n) (o_ready & ~o_grant) == '0);
  a_flit_stable:  assert property (@(posedge clk) disable iff (!rst_n) o_valid && !i_ready |=> $stable(o_flit));
endmodule

// File: tb/tb_tnoc_flit_vc_arbiter.sv
// tb_tnoc_flit_vc_arbiter: directed checks of packet locking, rotation, backpressure and reset
module tb_tnoc_flit_vc_arbiter;
  localparam int R  = 4;
  localparam int FW = 16;
  logic            clk = 0, rst_n = 1;
  logic [R-1:0]    i_valid = '0, o_ready, o_vc_available, o_grant;
  logic [R*FW-1:0] i_flit = '0;
  logic            o_valid, i_ready = 1, i_vc_available = 1, o_busy;
  logic [FW-1:0]   o_flit;
  int              checks = 0, errors = 0;
  tnoc_flit_vc_arbiter #(.REQUESTERS(R), .FLIT_WIDTH(FW)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_flit(i_flit),
    .o_vc_available(o_vc_available), .o_valid(o_valid), .i_ready(i_ready), .o_flit(o_flit),
    .i_vc_available(i_vc_available), .o_grant(o_grant), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [FW-1:0] mk(input int r, input int s, input bit h, input bit t);
    return {4'(r), 10'(s), t, h};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int k, input logic [FW-1:0] f);
    i_valid[k] = 1'b1;
    i_flit[k*FW +: FW] = f;
  endtask
  initial begin
    #1 rst_n = 0;
    drive(0, mk(0, 1, 1, 0));
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_flit", o_flit, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_ready, 0);
    cyc(); cyc();
    rst_n = 1;
    // single 3-flit packet from req0
    #1 chk("p1_grant", o_grant, 4'b0001);
    chk("p1_ready", o_ready, 4'b0001);
    cyc(); chk("p1_h", o_flit, mk(0, 1, 1, 0)); chk("p1_busy_h", o_busy, 1);
    drive(0, mk(0, 2, 0, 0));
    cyc(); chk("p1_b", o_flit, mk(0, 2, 0, 0)); chk("p1_busy_b", o_busy, 1);
    drive(0, mk(0, 3, 0, 1));
    cyc(); chk("p1_t", o_flit, mk(0, 3, 0, 1)); chk("p1_busy_t", o_busy, 0);
    i_valid = '0;
    cyc(); chk("p1_idle_valid", o_valid, 0); chk("p1_hold_flit", o_flit, mk(0, 3, 0, 1));
    // pointer is 1: req1 beats req0
    drive(0, mk(0, 4, 1, 1)); drive(1, mk(1, 4, 1, 1));
    #1 chk("ptr1_grant", o_grant, 4'b0010);
    cyc(); chk("ptr1_flit", o_flit, mk(1, 4, 1, 1));
    i_valid = '0; drive(3, mk(3, 5, 1, 1));
    #1 chk("ptr2_grant", o_grant, 4'b1000);
    cyc(); chk("ptr2_flit", o_flit, mk(3, 5, 1, 1));
    // contention from pointer 0: req0, req1, req3 back to back
    i_valid = '0;
    drive(0, mk(0, 6, 1, 0)); drive(1, mk(1, 6, 1, 0)); drive(3, mk(3, 6, 1, 0));
    #1 chk("ct_grant0", o_grant, 4'b0001);
    cyc(); chk("ct_h0", o_flit, mk(0, 6, 1, 0));
    drive(0, mk(0, 7, 0, 1));
    #1 chk("ct_ready_t0", o_ready, 4'b0001);
    cyc(); chk("ct_t0", o_flit, mk(0, 7, 0, 1));
    i_valid[0] = 0;
    #1 chk("ct_grant1", o_grant, 4'b0010);
    cyc(); chk("ct_h1", o_flit, mk(1, 6, 1, 0));
    drive(1, mk(1, 7, 0, 1));
    cyc(); chk("ct_t1", o_flit, mk(1, 7, 0, 1));
    i_valid[1] = 0;
    #1 chk("ct_grant3", o_grant, 4'b1000);
    cyc(); chk("ct_h3", o_flit, mk(3, 6, 1, 0)); chk("ct_v3", o_valid, 1);
    drive(3, mk(3, 7, 0, 1));
    cyc(); chk("ct_t3", o_flit, mk(3, 7, 0, 1));
    i_valid[3] = 0; drive(0, mk(0, 8, 1, 1)); drive(1, mk(1, 8, 1, 1));
    #1 chk("wrap_grant", o_grant, 4'b0001);
    cyc(); chk("wrap_flit", o_flit, mk(0, 8, 1, 1));
    i_valid = '0;
    cyc(); chk("wrap_idle", o_valid, 0);
    // lock held across req1 bubble while req2 waits with a head
    drive(1, mk(1, 9, 1, 0)); drive(2, mk(2, 9, 1, 0));
    #1 chk("il_grant", o_grant, 4'b0010);
    cyc(); chk("il_h1", o_flit, mk(1, 9, 1, 0));
    drive(1, mk(1, 10, 0, 0));
    #1 chk("il_ready_b", o_ready, 4'b0010);
    cyc(); chk("il_b1", o_flit, mk(1, 10, 0, 0));
    i_valid[1] = 0;
    #1 chk("il_bub_ready", o_ready, 4'b0000); chk("il_bub_grant", o_grant, 4'b0010);
    cyc(); chk("il_bub_valid", o_valid, 0);
    drive(1, mk(1, 11, 0, 1));
    #1 chk("il_ready_t", o_ready, 4'b0010);
    cyc(); chk("il_t1", o_flit, mk(1, 11, 0, 1));
    i_valid[1] = 0;
    #1 chk("il_grant2", o_grant, 4'b0100);
    cyc(); chk("il_h2", o_flit, mk(2, 9, 1, 0));
    drive(2, mk(2, 10, 0, 1));
    cyc(); chk("il_t2", o_flit, mk(2, 10, 0, 1));
    i_valid = '0;
    // backpressure on req3 packet
    drive(3, mk(3, 12, 1, 0));
    cyc(); chk("bp_h", o_flit, mk(3, 12, 1, 0));
    i_ready = 0; drive(3, mk(3, 13, 0, 0));
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", o_ready, 4'b0000);
      cyc(); chk("bp_flit", o_flit, mk(3, 12, 1, 0)); chk("bp_valid", o_valid, 1);
    end
    i_ready = 1;
    #1 chk("bp_resume_ready", o_ready, 4'b1000);
    cyc(); chk("bp_b", o_flit, mk(3, 13, 0, 0));
    drive(3, mk(3, 14, 0, 1));
    cyc(); chk("bp_t", o_flit, mk(3, 14, 0, 1));
    i_valid = '0;
    cyc(); chk("bp_idle", o_valid, 0);
    // vc_available gates packet start only
    i_vc_available = 0; drive(2, mk(2, 15, 1, 0));
    #1 chk("vc_grant_off", o_grant, 4'b0000); chk("vc_ready_off", o_ready, 4'b0000);
    chk("vc_bcast0", o_vc_available, 4'b0000);
    cyc(); chk("vc_novalid", o_valid, 0);
    i_vc_available = 1;
    #1 chk("vc_grant_on", o_grant, 4'b0100); chk("vc_bcast1", o_vc_available, 4'b1111);
    cyc(); chk("vc_h", o_flit, mk(2, 15, 1, 0));
    drive(2, mk(2, 16, 0, 0)); i_vc_available = 0;
    #1 chk("vc_locked_ready", o_ready, 4'b0100);
    cyc(); chk("vc_b", o_flit, mk(2, 16, 0, 0));
    drive(2, mk(2, 17, 0, 1));
    cyc(); chk("vc_t", o_flit, mk(2, 17, 0, 1)); chk("vc_busy", o_busy, 0);
    i_valid = '0; i_vc_available = 1;
    // async reset while req1 is locked
    drive(1, mk(1, 18, 1, 0));
    cyc(); chk("ar_h", o_flit, mk(1, 18, 1, 0)); chk("ar_busy", o_busy, 1);
    drive(1, mk(1, 19, 0, 0));
    #2 rst_n = 0;
    #1 chk("ar_valid", o_valid, 0); chk("ar_flit", o_flit, 0); chk("ar_busy0", o_busy, 0);
    chk("ar_grant", o_grant, 0); chk("ar_ready", o_ready, 0);
    drive(2, mk(2, 20, 1, 0));
    @(posedge clk); #1 rst_n = 1;
    #1 chk("ar_grant2", o_grant, 4'b0100); chk("ar_ready2", o_ready, 4'b0100);
    cyc(); chk("ar_h2", o_flit, mk(2, 20, 1, 0)); chk("ar_v2", o_valid, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
